// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked sharing of one UART transmitter between
// NUM_REQ byte streams, with a watchdog on the send/busy handshake.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                     ipClk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       ipReqValid,
    input  logic [NUM_REQ*WIDTH-1:0] ipReqData,
    input  logic [NUM_REQ-1:0]       ipReqLast,
    output logic [NUM_REQ-1:0]       opReqReady,
    output logic [NUM_REQ-1:0]       opGrant,
    output logic [WIDTH-1:0]         opTxData,
    output logic                     opTxSend,
    input  logic                     ipTxBusy,
    output logic                     opTimeout,
    output logic                     opIdle
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(BUSY_TIMEOUT);
    localparam logic [TW-1:0] T_LAST  = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               send_q, send_d;
    logic               timeout_q, timeout_d;
    logic               idle_q, idle_d;
    logic               last_q, last_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [WIDTH-1:0]   data_a [NUM_REQ];
    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic [CW-1:0]      cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_a[i] = ipReqData[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the requester after the last owner, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_vld && ipReqValid[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        ready_d   = '0;
        data_d    = data_q;
        send_d    = send_q;
        timeout_d = 1'b0;
        last_d    = last_q;
        timer_d   = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (!ipTxBusy && win_vld) begin
                    owner_d = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    ready_d = NUM_REQ'(1) << win_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = data_a[owner_q];
                last_d  = ipReqLast[owner_q];
                timer_d = '0;
                send_d  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (timer_q != T_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                // timer_q counts send cycles already completed
                if (ipTxBusy) begin
                    send_d  = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (timer_q == T_LAST) begin
                    timeout_d = 1'b1;
                    send_d    = 1'b0;
                    grant_d   = '0;
                    ptr_d     = owner_q;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                send_d = 1'b0;
                if (!ipTxBusy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_q;
                        state_d = S_IDLE;
                    end else if (ipReqValid[owner_q]) begin
                        ready_d = grant_q;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (ipReqValid[owner_q]) begin
                    ready_d = grant_q;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge ipClk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            owner_q   <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            data_q    <= '0;
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= 1'b1;
            last_q    <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            send_q    <= send_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
        end
    end

    assign opReqReady = ready_q;
    assign opGrant    = grant_q;
    assign opTxData   = data_q;
    assign opTxSend   = send_q;
    assign opTimeout  = timeout_q;
    assign opIdle     = idle_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART model,
// per-requester byte feeders and grant/byte/ready monitors.
module tb_uart_tx_scheduler;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int BT       = 1023;
    localparam int BUSY_LEN = 4340;

    logic         ipClk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] ipReqValid = '0;
    logic [N*W-1:0] ipReqData = '0;
    logic [N-1:0] ipReqLast = '0;
    logic [N-1:0] opReqReady;
    logic [N-1:0] opGrant;
    logic [W-1:0] opTxData;
    logic         opTxSend;
    logic         ipTxBusy = 1'b0;
    logic         opTimeout;
    logic         opIdle;

    uart_tx_scheduler #(
        .NUM_REQ(N),
        .WIDTH(W),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .ipClk(ipClk),
        .reset(reset),
        .ipReqValid(ipReqValid),
        .ipReqData(ipReqData),
        .ipReqLast(ipReqLast),
        .opReqReady(opReqReady),
        .opGrant(opGrant),
        .opTxData(opTxData),
        .opTxSend(opTxSend),
        .ipTxBusy(ipTxBusy),
        .opTimeout(opTimeout),
        .opIdle(opIdle)
    );

    always #5 ipClk = ~ipClk;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    // UART model: busy rises rise_dly cycles after send, then holds
    int   mst = 0;
    int   mcnt = 0;
    int   rise_dly = 3;
    bit   never = 1'b0;
    logic [7:0] blog [64];
    int   bn = 0;

    always @(posedge ipClk) begin
        case (mst)
            0: begin
                if (opTxSend && !never) begin
                    mst = 1;
                    mcnt = 1;
                end
            end
            1: begin
                if (mcnt >= rise_dly) begin
                    ipTxBusy <= 1'b1;
                    if (bn < 64) blog[bn] = opTxData;
                    bn++;
                    mst = 2;
                    mcnt = 1;
                end else begin
                    mcnt++;
                end
            end
            default: begin
                if (mcnt >= BUSY_LEN) begin
                    ipTxBusy <= 1'b0;
                    mst = 0;
                end else begin
                    mcnt++;
                end
            end
        endcase
    end

    // Requester feeders: byte streams with optional pause point
    logic [8:0] mem [N][16];
    int   rp [N];
    int   len [N];
    bit   pause [N];
    int   pause_at [N];
    logic [N-1:0] acc;
    bit   v;

    always begin
        @(posedge ipClk);
        acc = ipReqValid & opReqReady;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) rp[i]++;
            v = (rp[i] < len[i]) && !(pause[i] && rp[i] == pause_at[i]);
            ipReqValid[i] = v;
            ipReqData[i*W +: W] = v ? mem[i][rp[i]][7:0] : 8'h00;
            ipReqLast[i] = v ? mem[i][rp[i]][8] : 1'b0;
        end
    end

    // Monitors
    int   rcnt [N];
    int   tocnt = 0;
    logic [N-1:0] glog [64];
    int   gn = 0;
    logic [N-1:0] pg = '0;

    always @(posedge ipClk) begin
        for (int i = 0; i < N; i++) begin
            if (opReqReady[i]) rcnt[i]++;
        end
        if (opTimeout) tocnt++;
        if (opGrant != '0 && pg == '0) begin
            if (gn < 64) glog[gn] = opGrant;
            gn++;
        end
        pg = opGrant;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expired(input string tag, input int c);
        ntot++;
        nfail++;
        $error("FAIL %s: wait expired after %0d cycles", tag, c);
    endtask

    task automatic put(input int r, input logic [7:0] d, input bit l);
        mem[r][len[r]] = {l, d};
        len[r]++;
    endtask

    function automatic bit streams_done();
        for (int i = 0; i < N; i++) begin
            if (rp[i] < len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (!(opIdle && !ipTxBusy && mst == 0 && streams_done())
               && c < 30000) begin
            @(negedge ipClk);
            c++;
        end
        if (c >= 30000) expired(tag, c);
    endtask

    int b0, g0, r0, r1, c, n, bad;

    initial begin
        // Reset state
        repeat (3) @(negedge ipClk);
        chk("rst_ready", 32'(opReqReady), 0);
        chk("rst_grant", 32'(opGrant), 0);
        chk("rst_txdata", 32'(opTxData), 0);
        chk("rst_send", 32'(opTxSend), 0);
        chk("rst_timeout", 32'(opTimeout), 0);
        chk("rst_idle", 32'(opIdle), 1);
        reset = 1'b0;

        // Single byte with latency checks
        @(negedge ipClk);
        b0 = bn;
        put(0, 8'hA5, 1'b1);
        @(negedge ipClk);
        chk("sb_nogrant_yet", 32'(opGrant), 0);
        @(negedge ipClk);
        chk("sb_grant", 32'(opGrant), 1);
        chk("sb_ready", 32'(opReqReady), 1);
        chk("sb_idle_low", 32'(opIdle), 0);
        chk("sb_send_low", 32'(opTxSend), 0);
        @(negedge ipClk);
        chk("sb_send", 32'(opTxSend), 1);
        chk("sb_data", 32'(opTxData), 32'hA5);
        chk("sb_ready_pulse", 32'(opReqReady), 0);
        wait_idle("sb_wait");
        chk("sb_grant_end", 32'(opGrant), 0);
        chk("sb_idle_end", 32'(opIdle), 1);
        chk("sb_byte", 32'(blog[b0]), 32'hA5);
        chk("sb_rcnt", 32'(rcnt[0]), 1);

        // Round-robin between req1 and req2
        rise_dly = 434;
        b0 = bn;
        g0 = gn;
        put(1, 8'h31, 1'b1);
        put(1, 8'h32, 1'b1);
        put(2, 8'h41, 1'b1);
        put(2, 8'h42, 1'b1);
        wait_idle("rr_wait");
        chk("rr_g0", 32'(glog[g0]), 2);
        chk("rr_g1", 32'(glog[g0+1]), 4);
        chk("rr_g2", 32'(glog[g0+2]), 2);
        chk("rr_g3", 32'(glog[g0+3]), 4);
        chk("rr_b0", 32'(blog[b0]), 32'h31);
        chk("rr_b1", 32'(blog[b0+1]), 32'h41);
        chk("rr_b2", 32'(blog[b0+2]), 32'h32);
        chk("rr_b3", 32'(blog[b0+3]), 32'h42);

        // Packet lock: req3 three bytes, req0 waiting
        rise_dly = 7;
        b0 = bn;
        g0 = gn;
        put(3, 8'h10, 1'b0);
        put(3, 8'h11, 1'b0);
        put(3, 8'h12, 1'b1);
        put(0, 8'h05, 1'b1);
        wait_idle("lock_wait");
        chk("lock_g0", 32'(glog[g0]), 8);
        chk("lock_g1", 32'(glog[g0+1]), 1);
        chk("lock_b0", 32'(blog[b0]), 32'h10);
        chk("lock_b1", 32'(blog[b0+1]), 32'h11);
        chk("lock_b2", 32'(blog[b0+2]), 32'h12);
        chk("lock_b3", 32'(blog[b0+3]), 32'h05);

        // HOLD: req2 pauses mid-packet while req0 is valid
        b0 = bn;
        g0 = gn;
        pause[2] = 1'b1;
        pause_at[2] = rp[2] + 1;
        put(2, 8'h20, 1'b0);
        put(2, 8'h21, 1'b1);
        put(0, 8'h06, 1'b1);
        c = 0;
        while (!(bn == b0 + 1 && !ipTxBusy) && c < 10000) begin
            @(negedge ipClk);
            c++;
        end
        if (c >= 10000) expired("hold_first", c);
        repeat (3) @(negedge ipClk);
        r0 = rcnt[0];
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge ipClk);
            if (opGrant != 4'h4 || opReqReady != '0 || opTxSend) bad++;
        end
        chk("hold_stable", 32'(bad), 0);
        chk("hold_grant", 32'(opGrant), 4);
        chk("hold_r0", 32'(rcnt[0] - r0), 0);
        pause[2] = 1'b0;
        wait_idle("hold_wait");
        chk("hold_g0", 32'(glog[g0]), 4);
        chk("hold_g1", 32'(glog[g0+1]), 1);
        chk("hold_b0", 32'(blog[b0]), 32'h20);
        chk("hold_b1", 32'(blog[b0+1]), 32'h21);
        chk("hold_b2", 32'(blog[b0+2]), 32'h06);

        // Watchdog: UART never acknowledges req1's byte
        never = 1'b1;
        r1 = rcnt[1];
        put(1, 8'h77, 1'b1);
        put(3, 8'h78, 1'b1);
        c = 0;
        while (!opTxSend && c < 100) begin
            @(negedge ipClk);
            c++;
        end
        if (c >= 100) expired("to_send", c);
        n = 0;
        while (opTxSend && n < 2000) begin
            n++;
            @(negedge ipClk);
        end
        chk("to_len", 32'(n), BT);
        chk("to_pulse", 32'(opTimeout), 1);
        chk("to_grant", 32'(opGrant), 0);
        chk("to_idle", 32'(opIdle), 1);
        never = 1'b0;
        b0 = bn;
        @(negedge ipClk);
        chk("to_pulse_end", 32'(opTimeout), 0);
        wait_idle("to_wait");
        chk("to_count", 32'(tocnt), 1);
        chk("to_next_grant", 32'(glog[gn-1]), 8);
        chk("to_next_byte", 32'(blog[b0]), 32'h78);
        chk("to_r1", 32'(rcnt[1] - r1), 1);

        // All four valid after reset, then reset during SEND
        rise_dly = 10;
        @(negedge ipClk);
        reset = 1'b1;
        @(negedge ipClk);
        reset = 1'b0;
        put(0, 8'hA0, 1'b1);
        put(1, 8'hA1, 1'b1);
        put(2, 8'hA2, 1'b1);
        put(3, 8'hA3, 1'b1);
        c = 0;
        while (opGrant == '0 && c < 100) begin
            @(negedge ipClk);
            c++;
        end
        if (c >= 100) expired("rs_grant_wait", c);
        chk("rs_first_grant", 32'(opGrant), 1);
        c = 0;
        while (!(ipTxBusy && opTxSend) && c < 100) begin
            @(negedge ipClk);
            c++;
        end
        if (c >= 100) expired("rs_send_wait", c);
        reset = 1'b1;
        len[2] = rp[2];
        len[3] = rp[3];
        @(negedge ipClk);
        reset = 1'b0;
        chk("rs_send", 32'(opTxSend), 0);
        chk("rs_grant", 32'(opGrant), 0);
        chk("rs_idle", 32'(opIdle), 1);
        r1 = rcnt[1];
        bad = 0;
        c = 0;
        while (ipTxBusy && c < 6000) begin
            if (opReqReady != '0) bad++;
            @(negedge ipClk);
            c++;
        end
        if (c >= 6000) expired("rs_busy_wait", c);
        chk("rs_no_ready", 32'(bad), 0);
        wait_idle("rs_wait");
        chk("rs_r1", 32'(rcnt[1] - r1), 1);
        chk("rs_next_grant", 32'(glog[gn-1]), 2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
